// File: rtl/core_io_axil.sv
// AXI4-Lite I/O master serving the core's IN/OUT instructions against a UART-Lite style
// peripheral: polls status, then reads RX data or writes TX data, reporting done/err.
module core_io_axil #(
    parameter int unsigned       ADDR_W       = 4,
    parameter int unsigned       DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RX_ADDR      = 'h0,
    parameter logic [ADDR_W-1:0] TX_ADDR      = 'h4,
    parameter logic [ADDR_W-1:0] STAT_ADDR    = 'h8,
    parameter int unsigned       RX_VALID_BIT = 0,
    parameter int unsigned       TX_FULL_BIT  = 3,
    parameter int unsigned       POLL_LIMIT   = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    // core request/done handshake
    input  logic                req_in_i,
    input  logic                req_out_i,
    input  logic [7:0]          req_wdata_i,
    output logic                req_ready_o,
    output logic                done_o,
    output logic [7:0]          done_rdata_o,
    output logic                done_err_o,
    // AXI4-Lite read channels
    output logic [ADDR_W-1:0]   araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rvalid_i,
    output logic                rready_o,
    // AXI4-Lite write channels
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (POLL_LIMIT > 0) ? $clog2(POLL_LIMIT + 1) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] D_AR   = 3'd3;
    localparam logic [2:0] D_R    = 3'd4;
    localparam logic [2:0] W_AW   = 3'd5;
    localparam logic [2:0] W_B    = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    logic [2:0]        state_q,      state_d;
    logic              is_in_q,      is_in_d;
    logic [7:0]        wbyte_q,      wbyte_d;
    logic [CNT_W-1:0]  poll_cnt_q,   poll_cnt_d;
    logic              req_ready_q,  req_ready_d;
    logic [ADDR_W-1:0] araddr_q,     araddr_d;
    logic              arvalid_q,    arvalid_d;
    logic              rready_q,     rready_d;
    logic [ADDR_W-1:0] awaddr_q,     awaddr_d;
    logic              awvalid_q,    awvalid_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [STRB_W-1:0] wstrb_q,      wstrb_d;
    logic              wvalid_q,     wvalid_d;
    logic              bready_q,     bready_d;
    logic              done_q,       done_d;
    logic              done_err_q,   done_err_d;
    logic [7:0]        done_rdata_q, done_rdata_d;

    logic accept_c;
    logic r_hs_c;
    logic b_hs_c;
    logic aw_open_c;
    logic w_open_c;
    logic last_poll_c;
    logic unused_c;

    assign accept_c    = req_ready_q && (req_in_i || req_out_i);
    assign r_hs_c      = rvalid_i && rready_q;
    assign b_hs_c      = bvalid_i && bready_q;
    assign aw_open_c   = awvalid_q && !awready_i;
    assign w_open_c    = wvalid_q && !wready_i;
    // The status read just completed is the last one allowed for this request.
    assign last_poll_c = (POLL_LIMIT != 0) && ((32'(poll_cnt_q) + 32'd1) == POLL_LIMIT);
    assign unused_c    = ^{rdata_i, rresp_i[0], bresp_i[0]};

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        is_in_d      = is_in_q;
        wbyte_d      = wbyte_q;
        poll_cnt_d   = poll_cnt_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        done_d       = 1'b0;
        done_err_d   = 1'b0;
        done_rdata_d = done_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    is_in_d    = req_in_i;
                    wbyte_d    = req_wdata_i;
                    poll_cnt_d = '0;
                    araddr_d   = STAT_ADDR;
                    arvalid_d  = 1'b1;
                    state_d    = S_AR;
                end
            end
            S_AR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (r_hs_c) begin
                    rready_d = 1'b0;
                    if (rresp_i[1]) begin
                        done_d     = 1'b1;
                        done_err_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (is_in_q && rdata_i[RX_VALID_BIT]) begin
                        araddr_d  = RX_ADDR;
                        arvalid_d = 1'b1;
                        state_d   = D_AR;
                    end else if (!is_in_q && !rdata_i[TX_FULL_BIT]) begin
                        awaddr_d  = TX_ADDR;
                        wdata_d   = DATA_W'(wbyte_q);
                        wstrb_d   = STRB_W'(1);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = W_AW;
                    end else begin
                        poll_cnt_d = poll_cnt_q + CNT_W'(1);
                        if (last_poll_c) begin
                            done_d     = 1'b1;
                            done_err_d = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = S_AR;
                        end
                    end
                end
            end
            D_AR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = D_R;
                end
            end
            D_R: begin
                if (r_hs_c) begin
                    rready_d     = 1'b0;
                    done_rdata_d = rdata_i[7:0];
                    done_d       = 1'b1;
                    done_err_d   = rresp_i[1];
                    state_d      = S_DONE;
                end
            end
            W_AW: begin
                // AW and W retire independently; move on once neither is outstanding.
                if (awvalid_q && awready_i) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready_i) begin
                    wvalid_d = 1'b0;
                    wstrb_d  = '0;
                end
                if (!aw_open_c && !w_open_c) begin
                    bready_d = 1'b1;
                    state_d  = W_B;
                end
            end
            W_B: begin
                if (b_hs_c) begin
                    bready_d   = 1'b0;
                    done_d     = 1'b1;
                    done_err_d = bresp_i[1];
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_in_q      <= 1'b0;
            wbyte_q      <= '0;
            poll_cnt_q   <= '0;
            req_ready_q  <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            awvalid_q    <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            done_q       <= 1'b0;
            done_err_q   <= 1'b0;
            done_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            is_in_q      <= is_in_d;
            wbyte_q      <= wbyte_d;
            poll_cnt_q   <= poll_cnt_d;
            req_ready_q  <= req_ready_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            done_q       <= done_d;
            done_err_q   <= done_err_d;
            done_rdata_q <= done_rdata_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign done_o       = done_q;
    assign done_err_o   = done_err_q;
    assign done_rdata_o = done_rdata_q;
    assign araddr_o     = araddr_q;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign awaddr_o     = awaddr_q;
    assign awvalid_o    = awvalid_q;
    assign wdata_o      = wdata_q;
    assign wstrb_o      = wstrb_q;
    assign wvalid_o     = wvalid_q;
    assign bready_o     = bready_q;

endmodule

// File: tb/tb_core_io_axil.sv
// Bench for core_io_axil: behavioural UART-Lite AXI slave plus a done scoreboard.
module tb_core_io_axil;

    logic        clk;
    logic        rst_n;
    logic        req_in_i, req_out_i;
    logic [7:0]  req_wdata_i;
    logic        req_ready_o, done_o, done_err_o;
    logic [7:0]  done_rdata_o;
    logic [3:0]  araddr_o, awaddr_o;
    logic        arvalid_o, arready_i, rvalid_i, rready_o;
    logic [31:0] rdata_i, wdata_o;
    logic [1:0]  rresp_i, bresp_i;
    logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
    logic [3:0]  wstrb_o;

    core_io_axil #(.POLL_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_in_i(req_in_i), .req_out_i(req_out_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .done_o(done_o), .done_rdata_o(done_rdata_o),
        .done_err_o(done_err_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } sb_item_t;

    sb_item_t    sb[$];
    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_done = 0;
    int          viol = 0;

    // slave configuration and logs
    logic [31:0] stat_q[$];
    logic [31:0] stat_default = 0;
    logic [31:0] rx_val = 0;
    logic [1:0]  rresp_cfg = 0;
    logic [1:0]  bresp_cfg = 0;
    int          aw_delay = 0;
    int          w_delay = 0;
    bit          r_stall = 0;
    bit          w_first = 0;
    logic [3:0]  strb_after_w = 4'hf;
    logic [3:0]  ar_log[$];
    logic [3:0]  aw_log[$];
    logic [31:0] w_log[$];
    logic [3:0]  ws_log[$];

    logic [59:0] all_outs;
    assign all_outs = {araddr_o, arvalid_o, rready_o, awaddr_o, awvalid_o, wdata_o, wstrb_o,
                       wvalid_o, bready_o, done_o, done_err_o, done_rdata_o, req_ready_o};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural AXI4-Lite slave with protocol checks; samples at the edge, drives 1 later.
    initial begin
        logic       p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
        logic [3:0] p_ara, p_awa, p_ws;
        logic [31:0] p_wd;
        bit aw_got, w_got;
        int aw_wait, w_wait;
        aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
        arready_i = 1'b1; rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0;
        awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b0; bresp_i = '0;
        forever begin
            @(posedge clk);
            p_arv = arvalid_o; p_arr = arready_i; p_ara = araddr_o;
            p_rv = rvalid_i;   p_rr = rready_o;
            p_awv = awvalid_o; p_awr = awready_i; p_awa = awaddr_o;
            p_wv = wvalid_o;   p_wr = wready_i;   p_wd = wdata_o; p_ws = wstrb_o;
            p_bv = bvalid_i;   p_br = bready_o;
            #1;
            if (!rst_n) begin
                rvalid_i = 1'b0; bvalid_i = 1'b0;
                aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
                continue;
            end
            if (p_arv && !p_arr && (!arvalid_o || araddr_o != p_ara)) viol++;
            if (p_awv && !p_awr && (!awvalid_o || awaddr_o != p_awa)) viol++;
            if (p_wv && !p_wr && (!wvalid_o || wdata_o != p_wd || wstrb_o != p_ws)) viol++;
            if (bready_o && (awvalid_o || wvalid_o)) viol++;
            if (p_rv && p_rr) rvalid_i = 1'b0;
            if (p_arv && p_arr) begin
                ar_log.push_back(p_ara);
                if (!r_stall) begin
                    rvalid_i = 1'b1;
                    rresp_i  = rresp_cfg;
                    if (p_ara == 4'h8)      rdata_i = (stat_q.size() != 0) ? stat_q.pop_front() : stat_default;
                    else if (p_ara == 4'h0) rdata_i = rx_val;
                    else                    rdata_i = 32'hdead_beef;
                end
            end
            if (p_bv && p_br) bvalid_i = 1'b0;
            if (p_awv && p_awr) begin
                aw_log.push_back(p_awa);
                aw_got = 1;
            end
            if (p_wv && p_wr) begin
                w_log.push_back(p_wd);
                ws_log.push_back(p_ws);
                w_got = 1;
                strb_after_w = wstrb_o;
                if (awvalid_o && !wvalid_o) w_first = 1;
            end
            if (aw_got && w_got) begin
                bvalid_i = 1'b1;
                bresp_i  = bresp_cfg;
                aw_got = 0; w_got = 0;
            end
            if (awvalid_o) begin awready_i = (aw_wait >= aw_delay); aw_wait++; end
            else begin awready_i = (aw_delay == 0); aw_wait = 0; end
            if (wvalid_o) begin wready_i = (w_wait >= w_delay); w_wait++; end
            else begin wready_i = (w_delay == 0); w_wait = 0; end
        end
    end

    // Completion monitor: pops the scoreboard on each DONE pulse.
    initial begin
        sb_item_t it;
        forever begin
            @(negedge clk);
            if (rst_n && done_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    it = sb.pop_front();
                    chk("done_rdata", 64'(done_rdata_o), 64'(it.rdata));
                    chk("done_err", 64'(done_err_o), 64'(it.err));
                    chk("latency", 64'(cyc - acc_cyc), 64'(it.lat));
                end
                n_done++;
                @(negedge clk);
                chk("done_pulse", 64'(done_o), 64'(0));
            end
        end
    end

    task automatic clear_logs();
        ar_log.delete(); aw_log.delete(); w_log.delete(); ws_log.delete(); stat_q.delete();
    endtask

    task automatic run_req(input bit do_in, input bit do_out, input logic [7:0] wb,
                           input logic [7:0] exp_rd, input bit exp_err, input int exp_lat);
        sb_item_t it;
        int start;
        int k;
        it.rdata = exp_rd; it.err = exp_err; it.lat = exp_lat;
        sb.push_back(it);
        k = 0;
        @(negedge clk);
        while (!req_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        start   = n_done;
        acc_cyc = cyc + 1;
        req_in_i = do_in; req_out_i = do_out; req_wdata_i = wb;
        @(negedge clk);
        req_in_i = 1'b0; req_out_i = 1'b0;
        k = 0;
        while (n_done == start && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 64'(n_done != start), 64'(1));
        @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; req_in_i = 1'b0; req_out_i = 1'b0; req_wdata_i = '0;
        #12;
        chk("reset_outputs", 64'(all_outs), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready_o), 64'(1));

        // IN, zero-wait, RX present
        clear_logs(); stat_q.push_back(32'h1); rx_val = 32'h41;
        run_req(1, 0, 8'h00, 8'h41, 0, 4);
        chk("in_ar_count", 64'(ar_log.size()), 64'(2));
        chk("in_ar0", 64'(ar_log[0]), 64'(4'h8));
        chk("in_ar1", 64'(ar_log[1]), 64'(4'h0));

        // OUT, TX not full
        clear_logs(); stat_q.push_back(32'h0);
        run_req(0, 1, 8'h5a, 8'h41, 0, 4);
        chk("out_ar_count", 64'(ar_log.size()), 64'(1));
        chk("out_aw_count", 64'(aw_log.size()), 64'(1));
        chk("out_awaddr", 64'(aw_log[0]), 64'(4'h4));
        chk("out_wdata", 64'(w_log[0]), 64'(32'h0000_005a));
        chk("out_wstrb", 64'(ws_log[0]), 64'(4'b0001));

        // OUT, TX full for 3 polls
        clear_logs();
        stat_q.push_back(32'h8); stat_q.push_back(32'h8); stat_q.push_back(32'h8); stat_q.push_back(32'h0);
        run_req(0, 1, 8'hc3, 8'h41, 0, 10);
        chk("poll_ar_count", 64'(ar_log.size()), 64'(4));
        chk("poll_w_count", 64'(w_log.size()), 64'(1));
        chk("poll_wdata", 64'(w_log[0]), 64'(32'h0000_00c3));

        // IN, status never valid: poll timeout
        clear_logs(); stat_default = 32'h0;
        run_req(1, 0, 8'h00, 8'h41, 1, 8);
        chk("tmo_ar_count", 64'(ar_log.size()), 64'(4));
        k = 0;
        foreach (ar_log[i]) if (ar_log[i] != 4'h8) k++;
        chk("tmo_no_rx_read", 64'(k), 64'(0));

        // OUT with delayed AWREADY and SLVERR response
        clear_logs(); stat_q.push_back(32'h0); aw_delay = 3; bresp_cfg = 2'b10; w_first = 0;
        run_req(0, 1, 8'h77, 8'h41, 1, 7);
        chk("w_before_aw", 64'(w_first), 64'(1));
        chk("wstrb_cleared", 64'(strb_after_w), 64'(0));
        chk("slow_aw_count", 64'(aw_log.size()), 64'(1));
        aw_delay = 0; bresp_cfg = 2'b00;

        // EXOKAY counts as OKAY
        clear_logs(); stat_q.push_back(32'h1); rx_val = 32'hffff_ff99; rresp_cfg = 2'b01;
        run_req(1, 0, 8'h00, 8'h99, 0, 4);

        // DECERR on the status read ends the request at once
        clear_logs(); stat_q.push_back(32'h1); rresp_cfg = 2'b11;
        run_req(1, 0, 8'h00, 8'h99, 1, 2);
        chk("decerr_ar_count", 64'(ar_log.size()), 64'(1));
        rresp_cfg = 2'b00;

        // Both requests high: IN wins
        clear_logs(); stat_q.push_back(32'h1); rx_val = 32'h12;
        run_req(1, 1, 8'hee, 8'h12, 0, 4);
        chk("prio_no_write", 64'(aw_log.size()), 64'(0));

        // Reset while waiting in S_R
        clear_logs(); r_stall = 1;
        @(negedge clk);
        req_in_i = 1'b1;
        @(negedge clk);
        req_in_i = 1'b0;
        k = 0;
        while (!rready_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reached_s_r", 64'(rready_o), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 64'(all_outs), 64'(0));
        @(negedge clk);
        r_stall = 0;
        rst_n = 1'b1;
        clear_logs();
        @(negedge clk);
        chk("req_ready_after_rst", 64'(req_ready_o), 64'(1));
        stat_q.push_back(32'h1); rx_val = 32'h5c;
        run_req(1, 0, 8'h00, 8'h5c, 0, 4);
        chk("post_rst_ar_count", 64'(ar_log.size()), 64'(2));

        repeat (3) @(negedge clk);
        chk("axi_protocol", 64'(viol), 64'(0));
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
